// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: memory request/ready handshake between the control FSM and the unified memory
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memwrite;
  modport master (output mem_req, iord, memwrite, input mem_ready);
  modport slave (input mem_req, iord, memwrite, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS core with wait-state tolerant memory handshake
module mips_multicycle_ctrl #(
  parameter int CNTW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_ctrl_if.master mem,
  input  logic [5:0]             op,
  input  logic                   zero,
  output logic                   irwrite,
  output logic                   pcen,
  output logic                   regwrite,
  output logic                   regdst,
  output logic                   memtoreg,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [1:0]             pcsrc,
  output logic [1:0]             aluop,
  output logic                   illegal,
  output logic [CNTW-1:0]        instret,
  output logic [3:0]             state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t state_q, state_d;
  logic [CNTW-1:0] instret_q;
  logic retire;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = mem.mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                         op == OP_RT ? RTYPEEX : op == OP_BEQ ? BEQEX :
                         op == OP_ADDI ? ADDIEX : op == OP_J ? JEX : FETCH;
      MEMADR:  state_d = op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = mem.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem.mem_ready ? FETCH : MEMWR;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // an illegal-opcode bounce from DECODE is deliberately not counted
  assign retire = state_d == FETCH && state_q inside {MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNTW'(retire);
    end
  assign instret = instret_q;
  assign state   = state_q;
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.iord     = 1'b0;
    mem.memwrite = 1'b0;
    irwrite      = 1'b0;
    pcen         = 1'b0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    illegal      = 1'b0;
    case (state_q)
      FETCH: begin
        mem.mem_req = 1'b1;
        alusrcb     = 2'b01;
        irwrite     = mem.mem_ready;
        pcen        = mem.mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op inside {OP_LW, OP_SW, OP_RT, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
      end
      MEMWR: begin
        mem.mem_req  = 1'b1;
        mem.iord     = 1'b1;
        mem.memwrite = mem.mem_ready;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = zero;
      end
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // reset must kill every strobe at once, even though FETCH would raise mem_req
    if (!reset) {mem.mem_req, mem.memwrite, irwrite, pcen, regwrite, illegal} = '0;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS core. It sequences the shared datapath (PC, IR, data and ALUOut registers, register file, and the unified instruction/data memory) through fetch, decode, execute, memory and writeback states. Memory accesses use a ready handshake so the block tolerates wait-stated memory. It also keeps a retired-instruction count and flags unsupported opcodes.

## Interface
- `CNTW`, default 32: width of the retired-instruction counter.

- `clk`  input  1  core clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `op`  input  6  opcode field from the IR (IR[31:26]).
- `zero`  input  1  ALU zero flag.
- `mem_ready`  input  1  memory has completed the requested access this cycle.
- `mem_req`  output  1  memory access request.
- `iord`  output  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  output  1  memory write strobe.
- `irwrite`  output  1  IR load enable.
- `pcen`  output  1  PC load enable.
- `regwrite`  output  1  register file write enable.
- `regdst`  output  1  destination register select: 1 = rd, 0 = rt.
- `memtoreg`  output  1  writeback data select: 1 = data register, 0 = ALUOut.
- `alusrca`  output  1  ALU A operand select: 0 = PC, 1 = register A.
- `alusrcb`  output  2  ALU B operand select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- `illegal`  output  1  one-cycle pulse when an unsupported opcode is decoded.
- `instret`  output  CNTW  count of retired instructions.
- `state`  output  4  current state encoding, for debug.

## Operation
- **States and encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Encodings 12–15 are unreachable and return to FETCH.
- **Supported opcodes:** lw=100011, sw=101011, R-type=000000, beq=000100, addi=001000, j=000010.
- **Transitions:**
  - FETCH→DECODE, only on `mem_ready`; otherwise hold.
  - DECODE dispatches on `op`:
    - lw or sw → MEMADR
    - R-type → RTYPEEX
    - beq → BEQEX
    - addi → ADDIEX
    - j → JEX
    - any other opcode → FETCH, with `illegal` pulsed for that cycle.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB on `mem_ready`; otherwise hold.
  - MEMWR→FETCH on `mem_ready`; otherwise hold.
  - RTYPEEX→RTYPEWB, ADDIEX→ADDIWB.
  - MEMWB, RTYPEWB, ADDIWB, BEQEX and JEX all → FETCH.
- **Per-state outputs.** Every output not listed below is 0 in that state.
  - FETCH: `mem_req`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsrc`=00; `irwrite`=`pcen`=`mem_ready`.
  - DECODE: `alusrca`=0, `alusrcb`=11, `aluop`=00.
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10, `aluop`=00.
  - MEMRD: `mem_req`=1, `iord`=1.
  - MEMWR: `mem_req`=1, `iord`=1, `memwrite`=`mem_ready`.
  - MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1.
  - RTYPEEX: `alusrca`=1, `alusrcb`=00, `aluop`=10.
  - RTYPEWB: `regwrite`=1, `regdst`=1, `memtoreg`=0.
  - ADDIWB: `regwrite`=1, `regdst`=0, `memtoreg`=0.
  - BEQEX: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcsrc`=01, `pcen`=`zero`.
  - JEX: `pcsrc`=10, `pcen`=1.
- **Signal derivation:** the state register is the only storage besides `instret`. Outputs are decoded combinationally from the state, gated by `mem_ready`/`zero` as listed.
- **`instret`:** increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX or JEX. It does not increment on an illegal-opcode return. It wraps modulo 2^CNTW.

## Timing
- **Reset:** while `reset`=0, `state`=FETCH, `instret`=0, `illegal`=0, and all strobes (`mem_req`, `irwrite`, `pcen`, `memwrite`, `regwrite`) are forced to 0. Mux selects show their FETCH values.
- **Reset assert mid-instruction:** takes effect immediately and asynchronously; no strobe may remain high.
- **Reset release:** the first rising edge with `reset`=1 evaluates FETCH normally.
- **Latency at zero wait states** (`mem_ready` tied to 1), FETCH entry to next FETCH entry:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- **Wait states:** each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes stay low during the wait, and `mem_req` stays high.
- **`mem_ready` outside FETCH/MEMRD/MEMWR:** ignored.
- **`illegal`:** high for exactly the DECODE cycle of the bad opcode.

## Test plan
- **Reset:** hold `reset`=0 mid-MEMRD → `state`=0, `instret`=0, all strobes 0 immediately. Release → FETCH asserts `mem_req` on the next cycle.
- **Zero-wait mix:** `mem_ready`=1, run the sequence lw, sw, R-type, addi, beq, j → dwell of 5, 4, 4, 4, 3, 3 cycles respectively; `instret`=6; per-state outputs match the table in Operation.
- **Branch:** beq with `zero`=1 → `pcen`=1 and `pcsrc`=01 in BEQEX. With `zero`=0 → `pcen`=0, and `instret` still increments.
- **Wait states:** `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMWR during a sw → sw takes 9 cycles; `irwrite`/`pcen`/`memwrite` pulse once each, only in the ready cycle.
- **Illegal opcode:** `op`=111111 → `illegal` pulses 1 cycle in DECODE, next state is FETCH, `instret` unchanged, no `regwrite` or `memwrite` asserted.
- **Counter wrap:** CNTW=4, retire 17 j instructions → `instret`=1.
